// File: rtl/scroll_latch_sequencer.sv
// Shadows the 16 CUS42 scroll/control bytes and replays the dirty ones into the
// CUS42/CUS43 latch port once per frame, starting at the falling edge of nVBLANK.
module scroll_latch_sequencer #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter bit          RESET_DIRTY   = 1'b1
) (
    input  logic       CLK_6M,
    input  logic       RST,
    input  logic       nVBLANK,
    input  logic       WR_EN,
    input  logic [3:0] WR_ADDR,
    input  logic [7:0] WR_DATA,
    input  logic       FORCE,
    output logic [2:0] CA,
    output logic [7:0] CD,
    output logic       LATCH0,
    output logic       LATCH1,
    output logic       BUSY,
    output logic       DONE
);

    localparam int unsigned NUM_ENTRIES = 16;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CNT_W       = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [IDX_W-1:0]         index_q;
    logic [IDX_W-1:0]         index_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic                     nvblank_q;
    logic                     start_c;
    logic                     load_c;
    logic                     latch0_d;
    logic                     latch1_d;
    logic                     busy_d;
    logic                     done_d;
    logic [NUM_ENTRIES-1:0]   dirty_q;
    logic [NUM_ENTRIES-1:0]   dirty_d;
    logic [DATA_W-1:0]        shadow_q [NUM_ENTRIES];

    // Falling edge of vertical blank launches a sequence.
    assign start_c = nvblank_q & ~nVBLANK;

    always_ff @(posedge CLK_6M or posedge RST) begin
        if (RST) begin
            nvblank_q <= 1'b0;
        end else begin
            nvblank_q <= nVBLANK;
        end
    end

    // State register.
    always_ff @(posedge CLK_6M or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            index_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_c) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (dirty_q[index_q]) begin
                    state_d = SETUP;
                end else if (index_q == LAST_IDX) begin
                    state_d = FINISH;
                end
            end
            SETUP: begin
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                state_d = (index_q == LAST_IDX) ? FINISH : SCAN;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath decode; strobes/flags are registered from the next state.
    always_comb begin
        index_d  = index_q;
        cnt_d    = '0;
        load_c   = 1'b0;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == FINISH);
        latch0_d = (state_d == STROBE) && !index_q[3];
        latch1_d = (state_d == STROBE) &&  index_q[3];
        case (state_q)
            IDLE: begin
                if (start_c) begin
                    index_d = '0;
                end
            end
            SCAN: begin
                if (dirty_q[index_q]) begin
                    load_c = 1'b1;
                end else if (index_q != LAST_IDX) begin
                    index_d = index_q + IDX_W'(1);
                end
            end
            STROBE: begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            HOLD: begin
                if (index_q != LAST_IDX) begin
                    index_d = index_q + IDX_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Dirty tracking: a CPU write or FORCE in the capture cycle outranks the clear.
    always_comb begin
        dirty_d = dirty_q;
        if (load_c) begin
            dirty_d[index_q] = 1'b0;
        end
        if (FORCE) begin
            dirty_d = '1;
        end
        if (WR_EN) begin
            dirty_d[WR_ADDR] = 1'b1;
        end
    end

    always_ff @(posedge CLK_6M or posedge RST) begin
        if (RST) begin
            dirty_q <= {NUM_ENTRIES{RESET_DIRTY}};
        end else begin
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge CLK_6M or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (WR_EN) begin
            shadow_q[WR_ADDR] <= WR_DATA;
        end
    end

    // Latch port registers; CA/CD hold their last value outside of a transfer.
    always_ff @(posedge CLK_6M or posedge RST) begin
        if (RST) begin
            CA     <= '0;
            CD     <= '0;
            LATCH0 <= 1'b0;
            LATCH1 <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            LATCH0 <= latch0_d;
            LATCH1 <= latch1_d;
            BUSY   <= busy_d;
            DONE   <= done_d;
            if (load_c) begin
                CA <= index_q[2:0];
                CD <= shadow_q[index_q];
            end
        end
    end

endmodule

// File: tb/tb_scroll_latch_sequencer.sv
// Bench for scroll_latch_sequencer: directed frames plus random writes, checked
// cycle by cycle against a frame-level model of which bytes go out and when.
module tb_scroll_latch_sequencer;

    localparam int unsigned S = 2;

    logic       CLK_6M = 1'b0;
    logic       RST;
    logic       nVBLANK;
    logic       WR_EN;
    logic [3:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic       FORCE;
    logic [2:0] CA;
    logic [7:0] CD;
    logic       LATCH0;
    logic       LATCH1;
    logic       BUSY;
    logic       DONE;

    int errors = 0;
    int checks = 0;

    // Reference state: CPU-visible shadow and pending flags.
    logic [7:0] sh_m [16];
    bit         dk_m [16];

    // In-frame stimulus: cycle (1 = first cycle after the start edge), kind 0=write 1=force.
    int ev_cyc[$];
    int ev_kind[$];
    int ev_addr[$];
    int ev_data[$];

    // Expected transfers of the frame.
    int ex_idx[$];
    int ex_cd[$];
    int ex_rise[$];
    int ex_done;
    int tscan [16];
    int refall_c = 0;
    int abort_c  = 0;

    scroll_latch_sequencer #(.STROBE_CYCLES(S), .RESET_DIRTY(1'b1)) dut (
        .CLK_6M (CLK_6M),
        .RST    (RST),
        .nVBLANK(nVBLANK),
        .WR_EN  (WR_EN),
        .WR_ADDR(WR_ADDR),
        .WR_DATA(WR_DATA),
        .FORCE  (FORCE),
        .CA     (CA),
        .CD     (CD),
        .LATCH0 (LATCH0),
        .LATCH1 (LATCH1),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    always #5 CLK_6M = ~CLK_6M;

    task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input int cyc);
        check("rst_ca", cyc, 32'(CA), 0);
        check("rst_cd", cyc, 32'(CD), 0);
        check("rst_latch0", cyc, 32'(LATCH0), 0);
        check("rst_latch1", cyc, 32'(LATCH1), 0);
        check("rst_busy", cyc, 32'(BUSY), 0);
        check("rst_done", cyc, 32'(DONE), 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            sh_m[i] = 8'h00;
            dk_m[i] = 1'b1;
        end
    endtask

    // Walk the 16 entries in order: dirty costs 3+S cycles, clean costs 1.
    task automatic build_expect();
        int t;
        bit d;
        logic [7:0] v;
        ex_idx.delete();
        ex_cd.delete();
        ex_rise.delete();
        t = 1;
        for (int i = 0; i < 16; i++) begin
            d = dk_m[i];
            v = sh_m[i];
            for (int k = 0; k < ev_cyc.size(); k++) begin
                if (ev_cyc[k] < t && (ev_kind[k] == 1 || ev_addr[k] == i)) begin
                    d = 1'b1;
                    if (ev_kind[k] == 0) v = 8'(ev_data[k]);
                end
            end
            tscan[i] = t;
            if (d) begin
                ex_idx.push_back(i);
                ex_cd.push_back(int'(v));
                ex_rise.push_back(t + 2);
                t += 3 + int'(S);
            end else begin
                t += 1;
            end
        end
        ex_done = t;
    endtask

    // After a frame an entry is pending only if touched at or after its scan.
    task automatic commit_model();
        bit nd;
        for (int i = 0; i < 16; i++) begin
            nd = 1'b0;
            for (int k = 0; k < ev_cyc.size(); k++) begin
                if (ev_cyc[k] >= tscan[i] && (ev_kind[k] == 1 || ev_addr[k] == i)) nd = 1'b1;
            end
            dk_m[i] = nd;
        end
        for (int k = 0; k < ev_cyc.size(); k++) begin
            if (ev_kind[k] == 0) sh_m[ev_addr[k]] = 8'(ev_data[k]);
        end
        ev_cyc.delete();
        ev_kind.delete();
        ev_addr.delete();
        ev_data.delete();
    endtask

    function automatic logic exp_strobe(input int c, input int chip);
        for (int k = 0; k < ex_idx.size(); k++) begin
            if (c >= ex_rise[k] && c < ex_rise[k] + int'(S) && (ex_idx[k] / 8) == chip) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int xfer_window(input int c);
        for (int k = 0; k < ex_idx.size(); k++) begin
            if (c >= ex_rise[k] - 1 && c <= ex_rise[k] + int'(S)) return k;
        end
        return -1;
    endfunction

    task automatic add_ev(input int c, input int kind, input int a, input int d);
        ev_cyc.push_back(c);
        ev_kind.push_back(kind);
        ev_addr.push_back(a);
        ev_data.push_back(d);
    endtask

    task automatic cpu_write(input int a, input int d, input bit with_force);
        @(posedge CLK_6M); #1;
        WR_EN   = 1'b1;
        WR_ADDR = 4'(a);
        WR_DATA = 8'(d);
        FORCE   = with_force;
        @(posedge CLK_6M); #1;
        WR_EN = 1'b0;
        FORCE = 1'b0;
        sh_m[a] = 8'(d);
        dk_m[a] = 1'b1;
        if (with_force) for (int i = 0; i < 16; i++) dk_m[i] = 1'b1;
    endtask

    task automatic run_frame();
        int k;
        build_expect();
        @(posedge CLK_6M); #1;
        nVBLANK = 1'b0;
        for (int c = 1; c <= ex_done + 3; c++) begin
            @(posedge CLK_6M); #1;
            WR_EN = 1'b0;
            FORCE = 1'b0;
            for (int e = 0; e < ev_cyc.size(); e++) begin
                if (ev_cyc[e] == c) begin
                    if (ev_kind[e] == 0) begin
                        WR_EN   = 1'b1;
                        WR_ADDR = 4'(ev_addr[e]);
                        WR_DATA = 8'(ev_data[e]);
                    end else begin
                        FORCE = 1'b1;
                    end
                end
            end
            if (refall_c != 0 && c == refall_c) nVBLANK = 1'b1;
            if (refall_c != 0 && c == refall_c + 2) nVBLANK = 1'b0;
            @(negedge CLK_6M);
            check("latch0", c, 32'(LATCH0), 32'(exp_strobe(c, 0)));
            check("latch1", c, 32'(LATCH1), 32'(exp_strobe(c, 1)));
            check("busy", c, 32'(BUSY), 32'(c <= ex_done));
            check("done", c, 32'(DONE), 32'(c == ex_done));
            k = xfer_window(c);
            if (k >= 0) begin
                check("ca", c, 32'(CA), 32'(ex_idx[k] % 8));
                check("cd", c, 32'(CD), 32'(ex_cd[k]));
            end
            if (c == abort_c) begin
                RST = 1'b1;
                #1;
                check_reset_outputs(c);
                model_reset();
                ev_cyc.delete();
                ev_kind.delete();
                ev_addr.delete();
                ev_data.delete();
                abort_c  = 0;
                refall_c = 0;
                @(posedge CLK_6M); #1;
                WR_EN   = 1'b0;
                FORCE   = 1'b0;
                nVBLANK = 1'b1;
                @(posedge CLK_6M); #1;
                RST = 1'b0;
                @(posedge CLK_6M);
                @(posedge CLK_6M);
                return;
            end
        end
        @(posedge CLK_6M); #1;
        WR_EN   = 1'b0;
        FORCE   = 1'b0;
        nVBLANK = 1'b1;
        @(posedge CLK_6M);
        @(posedge CLK_6M);
        commit_model();
        refall_c = 0;
    endtask

    initial begin
        int a, d, c1, c2;
        RST     = 1'b1;
        nVBLANK = 1'b1;
        WR_EN   = 1'b0;
        WR_ADDR = '0;
        WR_DATA = '0;
        FORCE   = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK_6M);
        #1;
        check_reset_outputs(0);
        RST = 1'b0;
        repeat (2) @(posedge CLK_6M);

        // All sixteen entries dirty out of reset, CD=0.
        run_frame();

        // Nine-bit hScroll 0x134 split over entries 0 and 1, then an idle frame.
        cpu_write(0, 8'h34, 1'b0);
        cpu_write(1, 8'h01, 1'b0);
        run_frame();
        run_frame();

        // Mid-frame writes: entry 2 before its scan, entry 0 after it was sent.
        cpu_write(0, 8'h11, 1'b0);
        add_ev(2, 0, 2, 8'hAA);
        add_ev(6, 0, 0, 8'h55);
        run_frame();
        run_frame();

        // Write coincident with the capture of entry 9.
        cpu_write(9, 8'h10, 1'b0);
        add_ev(10, 0, 9, 8'h77);
        run_frame();
        run_frame();

        // Reset during the strobe of entry 5 after FORCE+write, then full replay.
        cpu_write(5, 8'h5A, 1'b0);
        cpu_write(12, 8'hC3, 1'b1);
        abort_c = 1 + 5 * (3 + int'(S)) + 2;
        run_frame();
        run_frame();

        // Second nVBLANK fall while busy and a FORCE at the last scan.
        cpu_write(4, 8'h44, 1'b0);
        cpu_write(13, 8'hD1, 1'b0);
        build_expect();
        add_ev(tscan[15], 1, 0, 0);
        refall_c = 8;
        run_frame();
        run_frame();

        // Random writes around and inside frames.
        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < int'($urandom_range(0, 5)); n++) begin
                a = int'($urandom_range(0, 15));
                d = int'($urandom_range(0, 255));
                cpu_write(a, d, 1'b0);
            end
            c1 = int'($urandom_range(1, 7));
            c2 = int'($urandom_range(8, 16));
            add_ev(c1, 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
            add_ev(c2, ($urandom_range(0, 3) == 0) ? 1 : 0, int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 255)));
            run_frame();
        end
        run_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
